// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the per-core instruction fetch stage.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAP  = 2'd3
  } lane_state_t;

  localparam int unsigned NCORES_DEF    = 3;
  localparam int unsigned AW_DEF        = 8;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned RAM_LAT_DEF   = 2;
  localparam int unsigned STALL_MAX_DEF = 16;

  localparam int unsigned STALL_CW = 8;
  localparam int unsigned LAT_CW   = 3;

  // Low bit of lane `lane` inside a flat bus of `w`-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/imem_fetch_lane.sv
// One core's fetch lane: request/grant handshake, read-latency count, byte capture, stall flag.
module imem_fetch_lane
  import imem_fetch_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned RAM_LAT   = RAM_LAT_DEF,
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] pc,
  input  logic          acq,
  input  logic [DW-1:0] dq,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  output logic          busy,
  output logic          stall,
  output logic          rden,
  output logic [AW-1:0] addr
);

  lane_state_t         state;
  logic                req_seen;
  logic [LAT_CW-1:0]   lat_cnt;
  logic [STALL_CW-1:0] stall_cnt;
  logic [STALL_CW-1:0] stall_inc;

  assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_CW'(1);
  assign rden      = (state == ST_REQ);

  // req_seen gates acq until one full REQ cycle has elapsed, hiding stale grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_seen    <= 1'b0;
      lat_cnt     <= '0;
      stall_cnt   <= '0;
      stall       <= 1'b0;
      busy        <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr        <= '0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (fetch_req) begin
            state     <= ST_REQ;
            addr      <= pc;
            req_seen  <= 1'b0;
            stall_cnt <= '0;
            stall     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          req_seen  <= 1'b1;
          stall_cnt <= stall_inc;
          if (acq && req_seen) begin
            state   <= ST_WAIT;
            lat_cnt <= LAT_CW'(RAM_LAT - 1);
            stall   <= 1'b0;
          end else begin
            stall <= (stall_inc > STALL_CW'(STALL_MAX));
          end
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state       <= ST_CAP;
            instr       <= dq;
            instr_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_CW'(1);
          end
        end
        ST_CAP: begin
          if (fetch_req) begin
            state     <= ST_REQ;
            addr      <= pc;
            req_seen  <= 1'b0;
            stall_cnt <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Per-core instruction fetch stage: NCORES independent lanes packed onto the memory-controller bus.
module imem_fetch_unit
  import imem_fetch_pkg::*;
#(
  parameter int unsigned NCORES    = NCORES_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned RAM_LAT   = RAM_LAT_DEF,
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    fetch_req,
  input  logic [NCORES*AW-1:0] pc,
  output logic [NCORES*DW-1:0] instr,
  output logic [NCORES-1:0]    instr_valid,
  output logic [NCORES-1:0]    busy,
  output logic [NCORES-1:0]    stall,
  output logic [NCORES-1:0]    rden,
  output logic [NCORES-1:0]    wren,
  output logic [NCORES*AW-1:0] Address,
  output logic [NCORES*DW-1:0] Din,
  input  logic [NCORES-1:0]    acq,
  input  logic [NCORES*DW-1:0] Dq
);

  for (genvar i = 0; i < int'(NCORES); i++) begin : g_lane
    imem_fetch_lane #(
      .AW        (AW),
      .DW        (DW),
      .RAM_LAT   (RAM_LAT),
      .STALL_MAX (STALL_MAX)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req[i]),
      .pc          (pc[lane_lsb(i, AW) +: AW]),
      .acq         (acq[i]),
      .dq          (Dq[lane_lsb(i, DW) +: DW]),
      .instr       (instr[lane_lsb(i, DW) +: DW]),
      .instr_valid (instr_valid[i]),
      .busy        (busy[i]),
      .stall       (stall[i]),
      .rden        (rden[i]),
      .addr        (Address[lane_lsb(i, AW) +: AW])
    );
  end

  // Fetch path is read-only.
  assign wren = '0;
  assign Din  = '0;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed table, multi-cycle scenarios and random traffic vs a cycle-timeline model.
module tb_imem_fetch_unit;

  localparam int unsigned NC   = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int          LAT  = 2;
  localparam int          SMAX = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    fetch_req = '0;
  logic [NC*AW-1:0] pc = '0;
  logic [NC*DW-1:0] instr;
  logic [NC-1:0]    instr_valid, busy, stall, rden, wren;
  logic [NC*AW-1:0] Address;
  logic [NC*DW-1:0] Din;
  logic [NC-1:0]    acq = '0;
  logic [NC*DW-1:0] Dq = '0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  imem_fetch_unit #(
    .NCORES(NC), .AW(AW), .DW(DW), .RAM_LAT(LAT), .STALL_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .busy(busy), .stall(stall),
    .rden(rden), .wren(wren), .Address(Address), .Din(Din),
    .acq(acq), .Dq(Dq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Model: each lane is a timeline (first REQ cycle, accepted-grant cycle), not a state machine.
  bit          m_act  [NC];
  int          m_start[NC];
  int          m_gnt  [NC];
  logic [AW-1:0] m_addr [NC];
  logic [DW-1:0] m_instr[NC];

  task automatic model_reset();
    for (int i = 0; i < int'(NC); i++) begin
      m_act[i] = 1'b0; m_start[i] = 0; m_gnt[i] = -1;
      m_addr[i] = '0; m_instr[i] = '0;
    end
    cyc = 0;
  endtask

  task automatic model_expect(output logic [NC-1:0] r, output logic [NC-1:0] b,
                              output logic [NC-1:0] s, output logic [NC-1:0] v,
                              output logic [NC*DW-1:0] ins, output logic [NC*AW-1:0] ad);
    r = '0; b = '0; s = '0; v = '0;
    for (int i = 0; i < int'(NC); i++) begin
      if (m_act[i]) begin
        b[i] = 1'b1;
        if (m_gnt[i] < 0) begin
          r[i] = 1'b1;
          s[i] = (cyc - m_start[i]) > SMAX;
        end else begin
          v[i] = (cyc == m_gnt[i] + LAT + 1);
        end
      end
      ins[i*DW +: DW] = m_instr[i];
      ad[i*AW +: AW]  = m_addr[i];
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < int'(NC); i++) begin
      if (!m_act[i]) begin
        if (fetch_req[i]) begin
          m_act[i] = 1'b1; m_start[i] = cyc + 1; m_gnt[i] = -1; m_addr[i] = pc[i*AW +: AW];
        end
      end else if (m_gnt[i] < 0) begin
        if (acq[i] && cyc >= m_start[i] + 1) m_gnt[i] = cyc;
      end else if (cyc == m_gnt[i] + LAT) begin
        m_instr[i] = Dq[i*DW +: DW];
      end else if (cyc == m_gnt[i] + LAT + 1) begin
        if (fetch_req[i]) begin
          m_start[i] = cyc + 1; m_gnt[i] = -1; m_addr[i] = pc[i*AW +: AW];
        end else begin
          m_act[i] = 1'b0;
        end
      end
    end
  endtask

  // Compare the current cycle's outputs against the model, then clock once.
  task automatic step();
    logic [NC-1:0] er, eb, es, ev;
    logic [NC*DW-1:0] ei;
    logic [NC*AW-1:0] ea;
    model_expect(er, eb, es, ev, ei, ea);
    chk("rden",        32'(rden),        32'(er));
    chk("busy",        32'(busy),        32'(eb));
    chk("stall",       32'(stall),       32'(es));
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("instr",       32'(instr),       32'(ei));
    chk("Address",     32'(Address),     32'(ea));
    chk("wren",        32'(wren),        32'(0));
    chk("Din",         32'(Din),         32'(0));
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] r, input logic [NC*AW-1:0] p, input logic [NC-1:0] a);
    fetch_req = r; pc = p; acq = a; Dq = (NC*DW)'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; fetch_req = '0; pc = '0; acq = '0; Dq = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Directed lane-0 single fetch, one record per cycle.
  typedef struct {
    logic          req;
    logic [AW-1:0] pcv;
    logic          acq;
    logic [DW-1:0] dq;
    logic          rden;
    logic          busy;
    logic          valid;
    logic [DW-1:0] instr;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [7];

  task automatic run_table(input int n);
    for (int r = 0; r < n; r++) begin
      fetch_req = {2'b00, tbl[r].req};
      pc        = {16'h0000, tbl[r].pcv};
      acq       = {2'b00, tbl[r].acq};
      Dq        = {16'h0000, tbl[r].dq};
      chk("t_rden0",  32'(rden[0]),        32'(tbl[r].rden));
      chk("t_busy0",  32'(busy[0]),        32'(tbl[r].busy));
      chk("t_valid0", 32'(instr_valid[0]), 32'(tbl[r].valid));
      chk("t_instr0", 32'(instr[7:0]),     32'(tbl[r].instr));
      chk("t_addr0",  32'(Address[7:0]),   32'(tbl[r].addr));
      chk("t_idle12", 32'(busy[2:1]),      32'(0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int rcnt, vcnt, scnt;
    tbl[0] = '{1'b1, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h2A};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h2A};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2A};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2A};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h2A};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h2A};

    // Single fetch
    do_reset();
    run_table(7);

    // Reset while lane 0 waits on RAM latency
    do_reset();
    run_table(4);
    #2 rst = 1'b1;
    #1;
    chk("rst_instr", 32'(instr),       32'(0));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    chk("rst_busy",  32'(busy),        32'(0));
    chk("rst_stall", 32'(stall),       32'(0));
    chk("rst_rden",  32'(rden),        32'(0));
    chk("rst_addr",  32'(Address),     32'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_valid", 32'(instr_valid), 32'(0));
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin drive('0, '0, '0); step(); end
    run_table(7);

    // Stale grant: acq[1] held high across two fetches
    do_reset();
    rcnt = 0; vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      drive((k == 0 || k == 8) ? 3'b010 : 3'b000, (k == 8) ? 24'h001100 : 24'h001000, 3'b010);
      if (rden[1]) rcnt++;
      if (instr_valid[1]) vcnt++;
      step();
    end
    chk("stale_req_cycles", 32'(rcnt), 32'(4));
    chk("stale_valid_cnt",  32'(vcnt), 32'(2));

    // Shared address, simultaneous grant on all lanes
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive((k == 0) ? 3'b111 : 3'b000, 24'h050505, (k == 2) ? 3'b111 : 3'b000);
      step();
    end

    // Partial grant: lanes 0/1 first, lane 2 four cycles later
    do_reset();
    for (int k = 0; k < 13; k++) begin
      drive((k == 0) ? 3'b111 : 3'b000, 24'h070101,
            (k == 2) ? 3'b011 : ((k == 6) ? 3'b100 : 3'b000));
      step();
    end

    // Stall flag on lane 2
    do_reset();
    scnt = 0;
    for (int k = 0; k < 28; k++) begin
      drive((k <= 21) ? 3'b100 : 3'b000, 24'h330000, (k == 21) ? 3'b100 : 3'b000);
      if (stall[2]) scnt++;
      step();
    end
    chk("stall_cycles", 32'(scnt), 32'(4));

    // Random traffic with occasional resets
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive(3'($urandom), 24'($urandom), 3'($urandom & $urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
